// File: rtl/regfile_stream_ctrl_pkg.sv
// Shared sizing, FSM encoding and bench timing for the register-file stream controller.
package regfile_stream_ctrl_pkg;

    localparam int N_REGS = 32;
    localparam int ADRS_W = $clog2(N_REGS);
    localparam int DATA_W = 32;
    localparam int HCYCL  = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_OUT  = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // N_REGS is a power of two, so dropping the carry is the modulo wrap.
    function automatic logic [ADRS_W-1:0] adrs_inc(input logic [ADRS_W-1:0] a);
        return a + {{(ADRS_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/regfile_stream_ctrl_if.sv
// Command, stream and register-file port bundle of the stream controller.
interface regfile_stream_ctrl_if;
    import regfile_stream_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dump;
    logic [ADRS_W-1:0] cmd_base;
    logic [ADRS_W:0]   cmd_count;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [ADRS_W-1:0] rf_rd_adrs_a;
    logic [DATA_W-1:0] rf_q_a;
    logic [ADRS_W-1:0] rf_wr_adrs;
    logic [DATA_W-1:0] rf_wr_data;
    logic              rf_wr_en;

    modport master (
        input  cmd_valid, cmd_dump, cmd_base, cmd_count, in_valid, in_data, out_ready, rf_q_a,
        output cmd_ready, in_ready, out_valid, out_data, busy, done,
               rf_rd_adrs_a, rf_wr_adrs, rf_wr_data, rf_wr_en
    );

    modport slave (
        output cmd_valid, cmd_dump, cmd_base, cmd_count, in_valid, in_data, out_ready, rf_q_a,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done,
               rf_rd_adrs_a, rf_wr_adrs, rf_wr_data, rf_wr_en
    );

endinterface

// File: rtl/regfile_stream_addr_gen.sv
// Current register address and remaining-word counter for one LOAD/DUMP command.
module regfile_stream_addr_gen
    import regfile_stream_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADRS_W-1:0] i_base,
    input  logic [ADRS_W:0]   i_count,
    output logic [ADRS_W-1:0] o_adrs,
    output logic [ADRS_W-1:0] o_adrs_nxt,
    output logic              o_last
);

    logic [ADRS_W-1:0] r_adrs;
    logic [ADRS_W:0]   r_remaining;
    logic [ADRS_W-1:0] w_adrs_nxt;
    logic [ADRS_W:0]   w_remaining_nxt;

    // Next counter values: latch a new command, advance one word, or hold.
    always_comb begin
        w_adrs_nxt      = r_adrs;
        w_remaining_nxt = r_remaining;
        if (i_load) begin
            w_adrs_nxt      = i_base;
            w_remaining_nxt = i_count;
        end else if (i_step) begin
            w_adrs_nxt      = adrs_inc(r_adrs);
            w_remaining_nxt = r_remaining - {{ADRS_W{1'b0}}, 1'b1};
        end else begin
            w_adrs_nxt      = r_adrs;
            w_remaining_nxt = r_remaining;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_adrs      <= {ADRS_W{1'b0}};
            r_remaining <= {(ADRS_W+1){1'b0}};
        end else begin
            r_adrs      <= w_adrs_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    assign o_adrs     = r_adrs;
    assign o_adrs_nxt = w_adrs_nxt;
    assign o_last     = (r_remaining == {{ADRS_W{1'b0}}, 1'b1});

endmodule

// File: rtl/regfile_stream_ctrl.sv
// LOAD/DUMP streaming master for the CPU register file write port and read port A.
// Build macro RFS_SKIP_R0_EN: register 0 is hardwired to zero (no writes, reads return 0).
module regfile_stream_ctrl
    import regfile_stream_ctrl_pkg::*;
(
    input  logic                  i_clk_cpu,
    input  logic                  i_reset,
    regfile_stream_ctrl_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_cmd_acc;
    logic              w_beat;
    logic              w_out_hs;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_wr_keep;
    logic [ADRS_W-1:0] w_adrs;
    logic [ADRS_W-1:0] w_adrs_nxt;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_cmd_ready;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADRS_W-1:0] r_rd_adrs;
    logic [ADRS_W-1:0] r_wr_adrs;

    regfile_stream_addr_gen u_addr_gen (
        .i_clk      (i_clk_cpu),
        .i_rst      (i_reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_base     (bus.cmd_base),
        .i_count    (bus.cmd_count),
        .o_adrs     (w_adrs),
        .o_adrs_nxt (w_adrs_nxt),
        .o_last     (w_last)
    );

    // Ready flags are registered, so a handshake is only possible in the owning state.
    assign w_cmd_acc = bus.cmd_valid & r_cmd_ready;
    assign w_beat    = bus.in_valid & r_in_ready;
    assign w_out_hs  = bus.out_ready & r_out_valid;

`ifdef RFS_SKIP_R0_EN
    assign w_wr_keep = (w_adrs != {ADRS_W{1'b0}});
    assign w_rd_data = (w_adrs == {ADRS_W{1'b0}}) ? {DATA_W{1'b0}} : bus.rf_q_a;
`else
    assign w_wr_keep = 1'b1;
    assign w_rd_data = bus.rf_q_a;
`endif

    // Next-state and counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_acc) begin
                    w_load = 1'b1;
                    if (bus.cmd_count == {(ADRS_W+1){1'b0}}) begin
                        w_state_nxt = ST_FIN;
                    end else if (bus.cmd_dump) begin
                        w_state_nxt = ST_RD_ADDR;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? ST_FIN : ST_LOAD;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_RD_ADDR: w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = ST_RD_OUT;
            ST_RD_OUT: begin
                if (w_out_hs) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? ST_FIN : ST_RD_ADDR;
                end else begin
                    w_state_nxt = ST_RD_OUT;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; status flags follow the state being entered.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
            r_wr_data   <= {DATA_W{1'b0}};
            r_rd_adrs   <= {ADRS_W{1'b0}};
            r_wr_adrs   <= {ADRS_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FIN);
            r_in_ready  <= (w_state_nxt == ST_LOAD);
            r_wr_en     <= w_beat & w_wr_keep;
            if (w_beat) begin
                r_wr_adrs <= w_adrs;
                r_wr_data <= bus.in_data;
            end
            // Address is presented for the whole RD_ADDR cycle; it holds elsewhere.
            if (w_state_nxt == ST_RD_ADDR) begin
                r_rd_adrs <= w_adrs_nxt;
            end
            if (r_state == ST_RD_WAIT) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd_data;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.rf_rd_adrs_a = r_rd_adrs;
    assign bus.rf_wr_adrs   = r_wr_adrs;
    assign bus.rf_wr_data   = r_wr_data;
    assign bus.rf_wr_en     = r_wr_en;

endmodule

// File: tb/tb_regfile_stream_ctrl.sv
// Bench for regfile_stream_ctrl: register-file model, random LOAD/DUMP traffic, array reference model.
module tb_regfile_stream_ctrl;
    import regfile_stream_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_stream_ctrl_if bus ();

    regfile_stream_ctrl dut (
        .i_clk_cpu (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    always #HCYCL clk = ~clk;

    // Register file: synchronous write, read data one clock after the address; backdoor for preload.
    logic [DATA_W-1:0] rf_mem [N_REGS] = '{default: '0};
    logic              bk_we   = 1'b0;
    logic [ADRS_W-1:0] bk_adrs = '0;
    logic [DATA_W-1:0] bk_data = '0;
    always @(posedge clk) begin
        if (bk_we) rf_mem[bk_adrs] <= bk_data;
        else if (bus.rf_wr_en === 1'b1) rf_mem[bus.rf_wr_adrs] <= bus.rf_wr_data;
        bus.rf_q_a <= rf_mem[bus.rf_rd_adrs_a];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, done_cnt = 0, outv_cnt = 0, unstable = 0;
    int done_cyc = -1, acc_cyc = -1, last_hs_cyc = -1;
    logic [ADRS_W-1:0] wr_a_q [$];
    logic [DATA_W-1:0] wr_d_q [$];
    logic [DATA_W-1:0] out_q [$];
    logic [DATA_W-1:0] load_data [$];

    // Reference model: expected register contents and expected traffic.
    logic [DATA_W-1:0] exp_rf [N_REGS];
    logic [ADRS_W-1:0] exp_wa [$];
    logic [DATA_W-1:0] exp_wd [$];
    logic [DATA_W-1:0] exp_out [$];

    task automatic model_load(input int base, input int cnt);
        exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < cnt; i++) begin
            int a;
            bit wr;
            a  = (base + i) % N_REGS;
            wr = 1'b1;
`ifdef RFS_SKIP_R0_EN
            wr = (a != 0);
`endif
            if (wr) begin
                exp_rf[a] = load_data[i];
                exp_wa.push_back(ADRS_W'(a));
                exp_wd.push_back(load_data[i]);
            end
        end
    endtask

    task automatic model_dump(input int base, input int cnt);
        exp_out.delete();
        for (int i = 0; i < cnt; i++) begin
            int a;
            logic [DATA_W-1:0] v;
            a = (base + i) % N_REGS;
            v = exp_rf[a];
`ifdef RFS_SKIP_R0_EN
            if (a == 0) v = '0;
`endif
            exp_out.push_back(v);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (bus.rf_wr_en === 1'b1) begin
            wr_a_q.push_back(bus.rf_wr_adrs);
            wr_d_q.push_back(bus.rf_wr_data);
        end
        if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (bus.out_valid === 1'b1) outv_cnt++;
    endtask

    task automatic clear_obs();
        wr_a_q.delete(); wr_d_q.delete(); out_q.delete();
        done_cnt = 0; outv_cnt = 0; unstable = 0;
        done_cyc = -1; acc_cyc = -1; last_hs_cyc = -1;
    endtask

    task automatic send_cmd(input bit dump, input int base, input int cnt, input bit hold);
        int g = 0;
        bus.cmd_dump  = dump;
        bus.cmd_base  = ADRS_W'(base);
        bus.cmd_count = (ADRS_W+1)'(cnt);
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && g < 100) begin cycle(); g++; end
        n_tests++;
        if (g >= 100) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, g);
        end
        acc_cyc = cyc;
        cycle();
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int g = 0;
        while (done_cnt == start && g < 20) begin cycle(); g++; end
        bus.cmd_valid = 1'b0;
        n_tests++;
        if (g >= 20) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, required a pulse", g);
        end
        cycle();
    endtask

    // mode 0: in_valid always high, 1: every other cycle, 2: random.
    task automatic do_load(input int base, input int cnt, input int mode, input int abort_after, input bit hold);
        int idx = 0, g = 0, start;
        bit v;
        start = done_cnt;
        send_cmd(1'b0, base, cnt, hold);
        while (idx < cnt && idx != abort_after && g < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = load_data[idx];
            if (v && bus.in_ready === 1'b1) idx++;
            cycle(); g++;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (g >= 4000) begin
            n_fail++;
            $display("FAIL load_beat_timeout: %0d of %0d beats accepted", idx, cnt);
        end
        if (abort_after < 0) wait_done(start);
    endtask

    task automatic do_dump(input int base, input int cnt, input int stall_first, input bit rnd);
        int idx = 0, g = 0, stall = 0, start;
        bit r;
        bit pv = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        start = done_cnt;
        send_cmd(1'b1, base, cnt, 1'b0);
        while (idx < cnt && g < 4000) begin
            if (pv && (bus.out_valid !== 1'b1 || bus.out_data !== pd)) unstable++;
            if (bus.out_valid === 1'b1 && idx == 0 && stall < stall_first) begin
                r = 1'b0; stall++;
            end else if (rnd) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            bus.out_ready = r;
            pv = (bus.out_valid === 1'b1) && !r;
            pd = bus.out_data;
            if (bus.out_valid === 1'b1 && r) begin
                out_q.push_back(bus.out_data); idx++; last_hs_cyc = cyc;
            end
            cycle(); g++;
        end
        bus.out_ready = 1'b0;
        n_tests++;
        if (g >= 4000) begin
            n_fail++;
            $display("FAIL dump_word_timeout: %0d of %0d words received", idx, cnt);
        end
        wait_done(start);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N_REGS; i++) exp_rf[i] = '0;
        rst = 1'b1;
        cycle(); cycle();
        n_tests++;
        if ({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.rf_wr_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: cmd_ready/in_ready/out_valid/busy/done/wr_en=%b, required 000000",
                     {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.rf_wr_en});
        end
        n_tests++;
        if (bus.rf_rd_adrs_a !== '0 || bus.rf_wr_adrs !== '0 || bus.rf_wr_data !== '0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: rd=%h wa=%h wd=%h od=%h, required all 0",
                     bus.rf_rd_adrs_a, bus.rf_wr_adrs, bus.rf_wr_data, bus.out_data);
        end
        rst = 1'b0;
        cycle(); cycle();
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid_load();
        load_data.delete();
        for (int i = 0; i < 5; i++) load_data.push_back($urandom);
        clear_obs();
        do_load(0, 5, 0, 3, 1'b0);
        n_tests++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_adrs !== ADRS_W'(2)) begin
            n_fail++;
            $display("FAIL mid_load_third_beat: wr_en=%b adrs=%h, required 1 2", bus.rf_wr_en, bus.rf_wr_adrs);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.rf_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_load_async_reset: wr_en=%b busy=%b in_ready=%b, required 0 0 0",
                     bus.rf_wr_en, bus.busy, bus.in_ready);
        end
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();
        n_tests++;
        if (done_cnt != 0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_after_reset: done pulses=%0d cmd_ready=%b, required 0 1", done_cnt, bus.cmd_ready);
        end
        model_load(0, 2);
        clear_obs();
        do_dump(0, N_REGS, 0, 1'b0);
        model_dump(0, N_REGS);
        for (int i = 0; i < N_REGS; i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL mid_load_dump[%0d]: got %h, required %h", i,
                         (i < out_q.size()) ? out_q[i] : 32'hx, exp_out[i]);
            end
        end
    endtask

    task automatic test_load_full();
        load_data.delete();
        for (int i = 0; i < N_REGS; i++) load_data.push_back(32'h100 + 32'(i));
        clear_obs();
        do_load(0, N_REGS, 1, -1, 1'b0);
        model_load(0, N_REGS);
        n_tests++;
        if (wr_a_q.size() != exp_wa.size() || done_cnt != 1) begin
            n_fail++;
            $display("FAIL load_full_counts: wr pulses=%0d done=%0d, required %0d 1", wr_a_q.size(), done_cnt, exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_a_q.size(); i++) begin
            n_tests++;
            if (wr_a_q[i] !== exp_wa[i] || wr_d_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL load_full_write[%0d]: got %h:%h, required %h:%h", i, wr_a_q[i], wr_d_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        for (int i = 0; i < N_REGS; i++) begin
            n_tests++;
            if (rf_mem[i] !== exp_rf[i]) begin
                n_fail++;
                $display("FAIL load_full_reg[%0d]: got %h, required %h", i, rf_mem[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_dump_stall();
        clear_obs();
        do_dump(5, 3, 4, 1'b0);
        model_dump(5, 3);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL dump_stall_word[%0d]: got %h, required %h", i,
                         (i < out_q.size()) ? out_q[i] : 32'hx, exp_out[i]);
            end
        end
        n_tests++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL dump_stall_hold: %0d unstable cycles, required 0", unstable);
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL dump_stall_done: done=%0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_wrap();
        load_data.delete();
        for (int i = 0; i < 4; i++) load_data.push_back($urandom);
        clear_obs();
        do_load(30, 4, 2, -1, 1'b0);
        model_load(30, 4);
        n_tests++;
        if (wr_a_q.size() != exp_wa.size()) begin
            n_fail++;
            $display("FAIL wrap_write_count: got %0d, required %0d", wr_a_q.size(), exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_a_q.size(); i++) begin
            n_tests++;
            if (wr_a_q[i] !== exp_wa[i] || wr_d_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: got %h:%h, required %h:%h", i, wr_a_q[i], wr_d_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        clear_obs();
        do_dump(30, 4, 0, 1'b1);
        model_dump(30, 4);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL wrap_dump[%0d]: got %h, required %h", i,
                         (i < out_q.size()) ? out_q[i] : 32'hx, exp_out[i]);
            end
        end
    endtask

    task automatic test_zero_and_busy();
        clear_obs();
        send_cmd(1'b0, 7, 0, 1'b0);
        wait_done(0);
        n_tests++;
        if (done_cnt != 1 || done_cyc != acc_cyc + 1 || wr_a_q.size() != 0 || outv_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_count: done=%0d at %0d wr=%0d outv=%0d, required 1 at %0d 0 0",
                     done_cnt, done_cyc, wr_a_q.size(), outv_cnt, acc_cyc + 1);
        end
        load_data.delete();
        for (int i = 0; i < 3; i++) load_data.push_back($urandom);
        clear_obs();
        do_load(12, 3, 0, -1, 1'b1);
        model_load(12, 3);
        repeat (4) cycle();
        n_tests++;
        if (wr_a_q.size() != exp_wa.size() || done_cnt != 1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cmd_ignored: wr=%0d done=%0d busy=%b, required %0d 1 0",
                     wr_a_q.size(), done_cnt, bus.busy, exp_wa.size());
        end
    endtask

`ifdef RFS_SKIP_R0_EN
    task automatic test_skip_r0();
        bk_we = 1'b1; bk_adrs = '0; bk_data = 32'hFACE_FACE;
        cycle();
        bk_we = 1'b0;
        load_data.delete();
        load_data.push_back(32'hDEAD); load_data.push_back(32'hBEEF);
        clear_obs();
        do_load(0, 2, 0, -1, 1'b0);
        model_load(0, 2);
        n_tests++;
        if (wr_a_q.size() != 1 || wr_a_q[0] !== ADRS_W'(1) || wr_d_q[0] !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL skip_r0_load: %0d writes, first %h:%h, required 1 write 01:0000beef",
                     wr_a_q.size(), (wr_a_q.size() > 0) ? wr_a_q[0] : 5'hx, (wr_d_q.size() > 0) ? wr_d_q[0] : 32'hx);
        end
        clear_obs();
        do_dump(0, 1, 0, 1'b0);
        n_tests++;
        if (out_q.size() != 1 || out_q[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL skip_r0_dump: got %h, required 0", (out_q.size() > 0) ? out_q[0] : 32'hx);
        end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int base, cnt;
            base = $urandom_range(0, N_REGS - 1);
            cnt  = $urandom_range(1, N_REGS);
            clear_obs();
            if ($urandom_range(0, 1) == 0) begin
                load_data.delete();
                for (int i = 0; i < cnt; i++) load_data.push_back($urandom);
                do_load(base, cnt, 2, -1, 1'b0);
                model_load(base, cnt);
                n_tests++;
                if (wr_a_q.size() != exp_wa.size() || done_cnt != 1) begin
                    n_fail++;
                    $display("FAIL random_load_count[%0d]: wr=%0d done=%0d, required %0d 1", t, wr_a_q.size(), done_cnt, exp_wa.size());
                end
                for (int i = 0; i < exp_wa.size() && i < wr_a_q.size(); i++) begin
                    n_tests++;
                    if (wr_a_q[i] !== exp_wa[i] || wr_d_q[i] !== exp_wd[i]) begin
                        n_fail++;
                        $display("FAIL random_load[%0d.%0d]: got %h:%h, required %h:%h", t, i, wr_a_q[i], wr_d_q[i], exp_wa[i], exp_wd[i]);
                    end
                end
            end else begin
                do_dump(base, cnt, 0, 1'b1);
                model_dump(base, cnt);
                n_tests++;
                if (out_q.size() != cnt || wr_a_q.size() != 0 || unstable != 0) begin
                    n_fail++;
                    $display("FAIL random_dump_count[%0d]: words=%0d wr=%0d unstable=%0d, required %0d 0 0",
                             t, out_q.size(), wr_a_q.size(), unstable, cnt);
                end
                for (int i = 0; i < cnt && i < out_q.size(); i++) begin
                    n_tests++;
                    if (out_q[i] !== exp_out[i]) begin
                        n_fail++;
                        $display("FAIL random_dump[%0d.%0d]: got %h, required %h", t, i, out_q[i], exp_out[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_dump  = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_reset_mid_load();
        test_load_full();
        test_dump_stall();
        test_wrap();
        test_zero_and_busy();
`ifdef RFS_SKIP_R0_EN
        test_skip_r0();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
